dual_rail_xor_n: RTL

Parametrised, registered dual-rail (true/false rail) N-input XOR for the masked/hiding AES datapath. Each accepted word is captured, evaluated as the bitwise XOR of NUM_IN operands and presented with a valid/ready handshake. Between evaluations the block drives an enforced precharge (spacer) phase with all rails at 0, giving one rail transition per bit per evaluation regardless of data. It replaces cascaded fixed-width 2- and 3-input dual-rail XOR cells at the AddRoundKey and MixColumns XOR points.

---
 rtl/dual_rail_xor_n_if.sv | 26 ++
 rtl/dual_rail_xor_n.sv | 119 +++++++++++
 2 files changed

// File: rtl/dual_rail_xor_n_if.sv
// Operand/result channel of the dual-rail XOR: true/false rails with valid/ready on both sides.
// slave is the XOR block's view, master the producer/consumer view.
interface drx_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 3
);
  logic [NUM_IN*WIDTH-1:0] in_t;
  logic [NUM_IN*WIDTH-1:0] in_f;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_t;
  logic [WIDTH-1:0]        out_f;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err;

  modport slave (
    input  in_t, in_f, in_valid, out_ready,
    output in_ready, out_t, out_f, out_valid, err
  );

  modport master (
    output in_t, in_f, in_valid, out_ready,
    input  in_ready, out_t, out_f, out_valid, err
  );
endinterface

// File: rtl/dual_rail_xor_n.sv
// Registered dual-rail NUM_IN-operand XOR with an enforced all-zero spacer between evaluations.
// Define DRX_RAIL_CHECK_EN to reject words carrying invalid rail codes and raise a sticky err.
module dual_rail_xor_n #(
  parameter int WIDTH      = 8,
  parameter int NUM_IN     = 3,
  parameter int PRE_CYCLES = 2
) (
  input  logic   clk,
  input  logic   rst,
  drx_if.slave   bus
);

  localparam int          OPW    = NUM_IN * WIDTH;
  localparam logic [3:0]  PRE_LD = 4'(PRE_CYCLES);

  typedef enum logic {PRE, EVAL} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [OPW-1:0]   opr_t_q, opr_t_d;
  logic [OPW-1:0]   opr_f_q, opr_f_d;
  logic             rdy;
  logic             code_ok;
  logic             accept;
  logic [WIDTH-1:0] res_t, res_f;

  assign rdy = (state_q == PRE) && (cnt_q == 4'd0);

`ifdef DRX_RAIL_CHECK_EN
  assign code_ok = &(bus.in_t ^ bus.in_f);
`else
  assign code_ok = 1'b1;
`endif

  assign accept = bus.in_valid && rdy && code_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PRE;
      cnt_q   <= PRE_LD;
      opr_t_q <= '0;
      opr_f_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opr_t_q <= opr_t_d;
      opr_f_q <= opr_f_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opr_t_d = opr_t_q;
    opr_f_d = opr_f_q;
    case (state_q)
      PRE: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        if (accept) begin
          state_d = EVAL;
          opr_t_d = bus.in_t;
          opr_f_d = bus.in_f;
        end
      end
      EVAL: begin
        // Clearing the operands on transfer is what returns every rail to 0.
        if (bus.out_ready) begin
          state_d = PRE;
          cnt_d   = PRE_LD;
          opr_t_d = '0;
          opr_f_d = '0;
        end
      end
      default: state_d = PRE;
    endcase
  end

  // Monotonic dual-rail XOR cascade: a spacer pair (0,0) on any input yields a spacer output.
  always_comb begin
    logic [WIDTH-1:0] a_t, a_f, b_t, b_f, n_t, n_f;
    a_t = opr_t_q[WIDTH-1:0];
    a_f = opr_f_q[WIDTH-1:0];
    b_t = '0;
    b_f = '0;
    n_t = '0;
    n_f = '0;
    for (int k = 1; k < NUM_IN; k++) begin
      b_t = opr_t_q[k*WIDTH +: WIDTH];
      b_f = opr_f_q[k*WIDTH +: WIDTH];
      n_t = (a_t & b_f) | (a_f & b_t);
      n_f = (a_t & b_t) | (a_f & b_f);
      a_t = n_t;
      a_f = n_f;
    end
    res_t = a_t;
    res_f = a_f;
  end

  always_comb begin
    bus.in_ready  = rdy;
    bus.out_valid = (state_q == EVAL);
    bus.out_t     = res_t;
    bus.out_f     = res_f;
  end

`ifdef DRX_RAIL_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if (bus.in_valid && rdy && !code_ok) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
